// File: rtl/adder_word.sv
// 32-bit carry-lookahead word adder: combinational sum/carry plus a one-stage registered copy.
// Define ADDER_WORD_FLAGS_EN to add zero/negative/overflow flags and their registered copies.
module adder_word #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_out_q,
  output logic             out_valid
`ifdef ADDER_WORD_FLAGS_EN
  ,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             zero_q,
  output logic             negative_q,
  output logic             overflow_q
`endif
);

  localparam int GROUPS = WIDTH / 4;

  logic [WIDTH-1:0]  bit_g;
  logic [WIDTH-1:0]  bit_p;
  logic [WIDTH-1:0]  bit_c;
  logic [GROUPS-1:0] grp_g;
  logic [GROUPS-1:0] grp_p;
  logic [GROUPS:0]   grp_c;

  assign bit_g = a & b;
  assign bit_p = a ^ b;

  // Each 4-bit group derives its internal carries directly from the group carry-in.
  genvar gi;
  generate
    for (gi = 0; gi < GROUPS; gi++) begin : g_group
      logic [3:0] g4;
      logic [3:0] p4;
      logic [3:0] c4;
      logic       cin;

      assign g4  = bit_g[4*gi +: 4];
      assign p4  = bit_p[4*gi +: 4];
      assign cin = grp_c[gi];

      assign c4[0] = cin;
      assign c4[1] = g4[0] | (p4[0] & cin);
      assign c4[2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & cin);
      assign c4[3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
                   | (p4[2] & p4[1] & p4[0] & cin);

      assign grp_g[gi] = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
                       | (p4[3] & p4[2] & p4[1] & g4[0]);
      assign grp_p[gi] = &p4;

      assign bit_c[4*gi +: 4] = c4;
    end
  endgenerate

  // Group carries ripple from carry_in using group generate/propagate.
  always_comb begin
    grp_c[0] = carry_in;
    for (int i = 0; i < GROUPS; i++) begin
      grp_c[i+1] = grp_g[i] | (grp_p[i] & grp_c[i]);
    end
  end

  assign sum       = bit_p ^ bit_c;
  assign carry_out = grp_c[GROUPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      out_valid   <= 1'b0;
    end else if (in_valid) begin
      sum_q       <= sum;
      carry_out_q <= carry_out;
      out_valid   <= 1'b1;
    end else begin
      out_valid   <= 1'b0;
    end
  end

`ifdef ADDER_WORD_FLAGS_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign zero     = ~|sum;
  assign negative = sum[WIDTH-1];
  assign overflow = bit_c[WIDTH-1] ^ carry_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
    end else if (in_valid) begin
      zero_q     <= zero;
      negative_q <= negative;
      overflow_q <= overflow;
    end
  end
`endif

endmodule

// File: tb/tb_adder_word.sv
// Self-checking bench for adder_word: directed and random combinational checks,
// plus a scoreboard for the registered path.
module tb_adder_word;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        carry_in;
  logic [31:0] sum;
  logic        carry_out;
  logic        in_valid;
  logic [31:0] sum_q;
  logic        carry_out_q;
  logic        out_valid;
`ifdef ADDER_WORD_FLAGS_EN
  logic zero, negative, overflow, zero_q, negative_q, overflow_q;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        v;
    logic        z;
    logic        n;
    logic        o;
  } exp_t;

  exp_t sb[$];
  exp_t model;

  adder_word #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .carry_in    (carry_in),
    .sum         (sum),
    .carry_out   (carry_out),
    .in_valid    (in_valid),
    .sum_q       (sum_q),
    .carry_out_q (carry_out_q),
    .out_valid   (out_valid)
`ifdef ADDER_WORD_FLAGS_EN
    ,
    .zero        (zero),
    .negative    (negative),
    .overflow    (overflow),
    .zero_q      (zero_q),
    .negative_q  (negative_q),
    .overflow_q  (overflow_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t golden(input logic [31:0] va, input logic [31:0] vb, input logic vc);
    exp_t e;
    logic [32:0] full;
    full = {1'b0, va} + {1'b0, vb} + {32'd0, vc};
    e.s  = full[31:0];
    e.co = full[32];
    e.v  = 1'b1;
    e.z  = (full[31:0] == 32'd0);
    e.n  = full[31];
    e.o  = (va[31] == vb[31]) && (full[31] != va[31]);
    return e;
  endfunction

  task automatic comb_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                          input logic vc);
    exp_t e;
    a = va; b = vb; carry_in = vc;
    #1;
    e = golden(va, vb, vc);
    check({tag, "_sum"}, {1'b0, sum}, {1'b0, e.s});
    check({tag, "_carry"}, {32'd0, carry_out}, {32'd0, e.co});
`ifdef ADDER_WORD_FLAGS_EN
    check({tag, "_zero"}, {32'd0, zero}, {32'd0, e.z});
    check({tag, "_neg"}, {32'd0, negative}, {32'd0, e.n});
    check({tag, "_ovf"}, {32'd0, overflow}, {32'd0, e.o});
`endif
  endtask

  // One clock step: drive, check the combinational result, push the expected
  // registered state, then pop and compare after the edge.
  task automatic reg_step(input string tag, input logic r, input logic v,
                          input logic [31:0] va, input logic [31:0] vb, input logic vc);
    exp_t e;
    exp_t got;
    rst = r; in_valid = v; a = va; b = vb; carry_in = vc;
    #1;
    e = golden(va, vb, vc);
    check({tag, "_comb_sum"}, {1'b0, sum}, {1'b0, e.s});
    if (r) begin
      model = '0;
    end else if (v) begin
      model = e;
    end else begin
      model.v = 1'b0;
    end
    sb.push_back(model);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({tag, "_sum_q"}, {1'b0, sum_q}, {1'b0, got.s});
    check({tag, "_carry_q"}, {32'd0, carry_out_q}, {32'd0, got.co});
    check({tag, "_valid"}, {32'd0, out_valid}, {32'd0, got.v});
`ifdef ADDER_WORD_FLAGS_EN
    check({tag, "_zero_q"}, {32'd0, zero_q}, {32'd0, got.z});
    check({tag, "_neg_q"}, {32'd0, negative_q}, {32'd0, got.n});
    check({tag, "_ovf_q"}, {32'd0, overflow_q}, {32'd0, got.o});
`endif
  endtask

  initial begin
    exp_t e;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    bit          stop_rand;

    model = '0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0;

    // Two reset cycles
    reg_step("rst0", 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    reg_step("rst1", 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);

    // Directed combinational vectors
    comb_vec("add5_3", 32'h0000_0005, 32'h0000_0003, 1'b0);
    comb_vec("ones_p1", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    comb_vec("max_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    comb_vec("ones_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    comb_vec("zeros", 32'h0000_0000, 32'h0000_0000, 1'b0);
    comb_vec("neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0);
    comb_vec("grp_edge", 32'h0000_000F, 32'h0000_0001, 1'b0);

    // Random sweep, stops at the first mismatch
    stop_rand = 1'b0;
    for (int i = 0; i < 1024 && !stop_rand; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      a = ra; b = rb; carry_in = rc;
      #1;
      e = golden(ra, rb, rc);
      checks++;
      assert ({carry_out, sum} === {e.co, e.s})
      else begin
        errors++;
        stop_rand = 1'b1;
        $error("FAIL rand%0d a=%h b=%h cin=%0d observed %h expected %h",
               i, ra, rb, rc, {carry_out, sum}, {e.co, e.s});
      end
    end

    // Realign to the clock before the registered sequence
    @(posedge clk);
    #1;
    reg_step("cap_ones", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    reg_step("hold1", 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0001, 1'b0);
    reg_step("cap_5_3", 1'b0, 1'b1, 32'h0000_0005, 32'h0000_0003, 1'b0);
    reg_step("cap_ovf", 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    reg_step("hold2", 1'b0, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
    reg_step("rst_win", 1'b1, 1'b1, 32'h0000_0005, 32'h0000_0006, 1'b0);
    reg_step("post_rst", 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0006, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_word.md
Name: adder_word

Overview:
- 32-bit two's-complement/unsigned word adder with carry-in and carry-out, used as the datapath adder in the core.
- Primary sum/carry path is purely combinational, with zero-cycle latency.
- Also provides a one-stage registered copy of the result with a valid flag, for pipelined consumers.
- Clocked portion uses one clock and a synchronous active-high reset.

Parameters:
- WIDTH, 32, operand/sum width in bits. Must be a multiple of 4; 32 is the only verified value.

Ports:
- clk  input  1  system clock; all registers update on rising edge
- rst  input  1  synchronous, active-high reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- carry_in  input  1  carry into bit 0
- sum  output  WIDTH  combinational sum, bits [WIDTH-1:0] of a+b+carry_in
- carry_out  output  1  combinational carry out of bit WIDTH-1
- in_valid  input  1  capture a, b, carry_in result into the output register this cycle
- sum_q  output  WIDTH  registered sum
- carry_out_q  output  1  registered carry_out
- out_valid  output  1  registered in_valid

Behaviour:
- Combinational path:
  - {carry_out, sum} = a + b + carry_in, computed modulo 2^(WIDTH+1).
  - No dependence on clk or rst.
  - Outputs must settle within 1 ns of simulation time after any input change; no delays in RTL.
- Arithmetic structure:
  - Built from WIDTH/4 4-bit carry-lookahead groups.
  - Per-bit generate g=a&b, propagate p=a^b, sum bit = p^c.
  - Each group forms group generate/propagate.
  - Group carries ripple (or use a second-level lookahead) from carry_in.
  - The behavioural "+" operator is not used in the synthesizable path.
- Unsigned and two's-complement semantics are identical. carry_out is the unsigned carry; signed overflow is not reported unless the optional feature is enabled.
- Registered path, on rising clk:
  - If rst=1: sum_q=0, carry_out_q=0, out_valid=0 (and flag registers=0 if enabled).
  - Else if in_valid=1: sum_q<=sum, carry_out_q<=carry_out, out_valid<=1.
  - Else: sum_q and carry_out_q hold their values; out_valid<=0.
- Latency: combinational outputs 0 cycles; registered outputs 1 cycle.
- Reset asserted in the same cycle as in_valid: reset wins, nothing is captured.
- Reset never affects the combinational sum/carry_out.
- Boundary results:
  - all-ones + 0 + 1 → sum=0, carry_out=1.
  - all-ones + all-ones + 1 → sum=all-ones, carry_out=1.
  - 0 + 0 + 0 → 0, carry 0.
- X/Z on any input may propagate to outputs. With known inputs, outputs must be fully known (0/1, never X).

Optional Feature:
- Macro ADDER_WORD_FLAGS_EN.
- When defined, adds outputs:
  - zero (1): sum==0
  - negative (1): sum[WIDTH-1]
  - overflow (1): signed overflow, i.e. carry into MSB XOR carry_out
  - zero_q, negative_q, overflow_q (1 each): registered with the same capture/reset rules as sum_q.
- When undefined, these ports and registers do not exist; all other behaviour is unchanged.

Test Plan:
- a=32'h0000_0005, b=32'h0000_0003, carry_in=0 → sum=32'h0000_0008, carry_out=0, checked 1 ns after apply.
- a=32'hFFFF_FFFF, b=0, carry_in=1 → sum=0, carry_out=1 (full carry ripple). With flags: zero=1, overflow=0.
- a=32'h7FFF_FFFF, b=1, carry_in=0 → sum=32'h8000_0000, carry_out=0. With flags: overflow=1, negative=1.
- 1024 random triples (a, b, carry_in) → {carry_out,sum} equals the golden a+b+carry_in every time; stop on first mismatch.
- Registered path:
  - rst=1 for 2 cycles → sum_q=0, carry_out_q=0, out_valid=0.
  - Then in_valid=1 with a=32'hFFFF_FFFF, b=32'hFFFF_FFFF, carry_in=1 → next edge sum_q=32'hFFFF_FFFF, carry_out_q=1, out_valid=1.
  - in_valid=0 → values hold, out_valid=0.
- rst=1 and in_valid=1 in the same cycle with a=5, b=6 → sum_q remains 0 and out_valid=0, while combinational sum=11 during that cycle.
